bcd_seg_scanner: RTL and testbench

BCD_SEG_SCANNER -- requirements
Module: bcd_seg_scanner

---
 rtl/bcd_seg_scanner_if.sv | 18 +
 rtl/bcd_seg_scanner.sv | 148 ++++++++++++++
 tb/tb_bcd_seg_scanner.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_seg_scanner_if.sv
// BCD input handshake between the binary-to-BCD converter (master) and the scanner (slave).
interface bcd_seg_scanner_if;
  logic [7:0] bcd_in;     // [7:4] tens, [3:0] units
  logic       bcd_valid;
  logic       bcd_ready;

  modport master (
    output bcd_in,
    output bcd_valid,
    input  bcd_ready
  );

  modport slave (
    input  bcd_in,
    input  bcd_valid,
    output bcd_ready
  );
endinterface

// File: rtl/bcd_seg_scanner.sv
// Two-digit multiplexed 7-segment scanner. Accepted BCD values wait in a pending register and are
// promoted to the display register only at frame boundaries, so a frame never mixes digits.
module bcd_seg_scanner #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GAP_CYC     = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_seg_scanner_if.slave   bcd,
  input  logic               blank_lz,
  output logic [6:0]         seg_n,
  output logic [1:0]         an_n,
  output logic               frame_done
);

  localparam int unsigned MaxDur = (REFRESH_DIV > GAP_CYC) ? REFRESH_DIV : GAP_CYC;
  localparam int unsigned CntW   = (MaxDur > 1) ? $clog2(MaxDur) : 1;
  localparam logic [CntW-1:0] ShowLast = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYC - 1);

  typedef enum logic [1:0] {StShowU, StGapU, StShowT, StGapT} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            dwell_done;
  logic            boundary;

  logic [7:0]      pend_q, disp_q;
  logic            full_q;
  logic            accept;

  logic [6:0]      seg_d;
  logic [1:0]      an_d;
  logic            frame_done_d;

  // Active-low segment patterns {g,f,e,d,c,b,a}; non-decimal codes show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // State register and shared dwell counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StShowU;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: each state exits when its dwell count reaches duration minus one.
  always_comb begin
    state_d    = state_q;
    dwell_done = 1'b0;
    unique case (state_q)
      StShowU: begin
        dwell_done = (cnt_q == ShowLast);
        if (dwell_done) state_d = StGapU;
      end
      StGapU: begin
        dwell_done = (cnt_q == GapLast);
        if (dwell_done) state_d = StShowT;
      end
      StShowT: begin
        dwell_done = (cnt_q == ShowLast);
        if (dwell_done) state_d = StGapT;
      end
      StGapT: begin
        dwell_done = (cnt_q == GapLast);
        if (dwell_done) state_d = StShowU;
      end
      default: state_d = StShowU;
    endcase
    cnt_d    = dwell_done ? '0 : cnt_q + 1'b1;
    boundary = (state_q == StGapT) && dwell_done;
  end

  assign bcd.bcd_ready = !full_q;
  assign accept        = bcd.bcd_valid && !full_q;

  // Pending/display registers; promotion at the boundary and a fresh accept may share an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 8'h00;
      disp_q <= 8'h00;
      full_q <= 1'b0;
    end else begin
      if (boundary && full_q) begin
        disp_q <= pend_q;
        full_q <= 1'b0;
      end
      if (accept) begin
        pend_q <= bcd.bcd_in;
        full_q <= 1'b1;
      end
    end
  end

  // Output decode from the current state; registered below, hence one cycle behind the state.
  always_comb begin
    an_d  = 2'b11;
    seg_d = 7'h7F;
    unique case (state_q)
      StShowU: begin
        an_d  = 2'b10;
        seg_d = seg_decode(disp_q[3:0]);
      end
      StShowT: begin
        an_d  = 2'b01;
        seg_d = (blank_lz && (disp_q[7:4] == 4'd0)) ? 7'h7F : seg_decode(disp_q[7:4]);
      end
      default: begin
        an_d  = 2'b11;
        seg_d = 7'h7F;
      end
    endcase
    frame_done_d = boundary;
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n      <= 7'h7F;
      an_n       <= 2'b11;
      frame_done <= 1'b0;
    end else begin
      seg_n      <= seg_d;
      an_n       <= an_d;
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Directed bench for bcd_seg_scanner with REFRESH_DIV=4, GAP_CYC=1 (frame of 10 cycles).
// A frame-position model pushes the expected {an_n, seg_n, frame_done, bcd_ready} per edge.
module tb_bcd_seg_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       blank_lz;
  logic [6:0] seg_n;
  logic [1:0] an_n;
  logic       frame_done;

  bcd_seg_scanner_if bif ();

  bcd_seg_scanner #(
    .REFRESH_DIV (4),
    .GAP_CYC     (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bcd        (bif.slave),
    .blank_lz   (blank_lz),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  int          checks = 0;
  int          errors = 0;
  int          n_edge = 0;
  logic [7:0]  m_disp = 8'h00;
  logic [7:0]  m_pend = 8'h00;
  logic        m_full = 1'b0;
  logic [10:0] exp_q [$];

  task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: predict this edge's outputs, advance the model, then compare after the edge.
  task automatic step();
    logic [1:0]  an_e;
    logic [6:0]  seg_e;
    logic        fd_e;
    logic        acc;
    logic [10:0] e;
    int          p;
    n_edge++;
    p = (n_edge - 1) % 10;
    if (p < 4) begin
      an_e  = 2'b10;
      seg_e = seg_tab[m_disp[3:0]];
    end else if (p == 4 || p == 9) begin
      an_e  = 2'b11;
      seg_e = 7'h7F;
    end else begin
      an_e  = 2'b01;
      seg_e = (blank_lz && m_disp[7:4] == 4'd0) ? 7'h7F : seg_tab[m_disp[7:4]];
    end
    fd_e = (n_edge % 10 == 0);
    acc  = bif.bcd_valid && !m_full;
    if (fd_e && m_full) begin
      m_disp = m_pend;
      m_full = 1'b0;
    end
    if (acc) begin
      m_pend = bif.bcd_in;
      m_full = 1'b1;
    end
    exp_q.push_back({an_e, seg_e, fd_e, !m_full});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check($sformatf("scan_e%0d", n_edge), {an_n, seg_n, frame_done, bif.bcd_ready}, e);
  endtask

  task automatic idle(input int k);
    bif.bcd_valid = 1'b0;
    for (int i = 0; i < k; i++) step();
  endtask

  // Offer v and keep bcd_valid high until the handshake edge; valid stays high on return.
  task automatic send(input logic [7:0] v);
    bit done;
    done          = 1'b0;
    bif.bcd_in    = v;
    bif.bcd_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      done = !m_full;
      step();
    end
    checks++;
    assert (done)
    else begin
      errors++;
      $error("FAIL send_timeout: value %h not accepted", v);
    end
  endtask

  task automatic align_boundary();
    bif.bcd_valid = 1'b0;
    for (int i = 0; i < 10 && (n_edge % 10) != 0; i++) step();
  endtask

  task automatic model_reset();
    n_edge = 0;
    m_disp = 8'h00;
    m_pend = 8'h00;
    m_full = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    rst_n         = 1'b0;
    blank_lz      = 1'b0;
    bif.bcd_in    = 8'h00;
    bif.bcd_valid = 1'b0;
    #12;
    check("reset_state", {an_n, seg_n, frame_done, bif.bcd_ready}, {2'b11, 7'h7F, 1'b0, 1'b1});
    rst_n = 1'b1;
    model_reset();

    // Idle scan: two full frames showing 00.
    idle(20);

    // 42 mid-frame; previous frame stays 00, then 42 from the boundary.
    idle(3);
    send(8'h42);
    idle(24);

    // 11 then 27 back to back; 27 waits for ready.
    send(8'h11);
    send(8'h27);
    idle(30);

    // Leading-zero blanking and dash.
    blank_lz = 1'b1;
    send(8'h07);
    idle(25);
    send(8'hA3);
    idle(25);

    // Valid held across the boundary while a value is pending.
    align_boundary();
    send(8'h55);
    bif.bcd_valid = 1'b0;
    for (int i = 0; i < 10 && (n_edge % 10) != 9; i++) step();
    send(8'h66);
    idle(25);

    // Reset during SHOW_T with a value pending.
    blank_lz = 1'b0;
    align_boundary();
    send(8'h38);
    bif.bcd_valid = 1'b0;
    for (int i = 0; i < 10 && (n_edge % 10) != 6; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {an_n, seg_n, frame_done, bif.bcd_ready}, {2'b11, 7'h7F, 1'b0, 1'b1});
    @(posedge clk);
    @(posedge clk);
    #3;
    check("reset_hold", {an_n, seg_n, frame_done, bif.bcd_ready}, {2'b11, 7'h7F, 1'b0, 1'b1});
    rst_n = 1'b1;
    model_reset();
    idle(22);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
